vga_pixel_fetch: RTL and testbench

VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

---
 rtl/vga_pkg.sv | 22 ++
 rtl/vga_palette.sv | 49 ++++
 rtl/vga_pixel_fetch.sv | 138 +++++++++++++
 tb/tb_vga_pixel_fetch.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants and types: visible raster size, coordinate and
// framebuffer address widths, 12-bit colour and 4-bit palette index types.
package vga_pkg;

  localparam int unsigned H_VISIBLE   = 640;
  localparam int unsigned V_VISIBLE   = 480;
  localparam int unsigned COORD_W     = 10;
  localparam int unsigned FB_ADDR_W   = 15;
  localparam int unsigned RGB_W       = 12;
  localparam int unsigned PAL_IDX_W   = 4;
  localparam int unsigned PAL_DEPTH   = 16;
  localparam int unsigned FRAME_CNT_W = 8;

  typedef logic [RGB_W-1:0]     rgb_t;
  typedef logic [PAL_IDX_W-1:0] pal_idx_t;

  // Power-on palette entry: grayscale ramp {i,i,i}
  function automatic rgb_t gray_entry(input pal_idx_t idx);
    return {idx, idx, idx};
  endfunction

endpackage

// File: rtl/vga_palette.sv
// Double-buffered 16-entry palette.
//   we/waddr/wdata : write into the shadow bank on the clock edge
//   commit         : copy the whole shadow bank into the active bank
//   raddr/rdata_c  : combinational read of the active bank
// A write coinciding with commit lands in the shadow only; the active bank
// takes the pre-write shadow contents.
module vga_palette
  import vga_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     we,
  input  pal_idx_t waddr,
  input  rgb_t     wdata,
  input  logic     commit,
  input  pal_idx_t raddr,
  output rgb_t     rdata_c
);

  rgb_t shadow [PAL_DEPTH];
  rgb_t active [PAL_DEPTH];

  // Shadow bank: CPU-side writes, last write wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(PAL_DEPTH); i++) begin
        shadow[i] <= gray_entry(PAL_IDX_W'(i));
      end
    end else if (we) begin
      shadow[waddr] <= wdata;
    end
  end

  // Active bank: whole-bank copy at frame boundary only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(PAL_DEPTH); i++) begin
        active[i] <= gray_entry(PAL_IDX_W'(i));
      end
    end else if (commit) begin
      for (int i = 0; i < int'(PAL_DEPTH); i++) begin
        active[i] <= shadow[i];
      end
    end
  end

  assign rdata_c = active[raddr];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Framebuffer pixel fetch for a VGA pipeline.
//   x, y, hsync, vsync, blank_b : raster position and timing from the controller
//   fb_addr / fb_data           : external synchronous RAM, 1-cycle read latency
//   pal_we/pal_addr/pal_data    : palette write port (double-buffered)
//   rgb, hsync_o, vsync_o, blank_b_o : colour and timing, 3 cycles after x/y
//   frame_start, frame_count    : per-frame pulse and 8-bit frame counter
module vga_pixel_fetch
  import vga_pkg::*;
#(
  parameter int unsigned FB_W       = 160,
  parameter int unsigned FB_H       = 120,
  parameter int unsigned SCALE_LOG2 = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [COORD_W-1:0]     x,
  input  logic [COORD_W-1:0]     y,
  input  logic                   hsync,
  input  logic                   vsync,
  input  logic                   blank_b,
  output logic [FB_ADDR_W-1:0]   fb_addr,
  input  pal_idx_t               fb_data,
  input  logic                   pal_we,
  input  pal_idx_t               pal_addr,
  input  rgb_t                   pal_data,
  output logic                   hsync_o,
  output logic                   vsync_o,
  output logic                   blank_b_o,
  output rgb_t                   rgb,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam int unsigned X_SPAN   = FB_W << SCALE_LOG2;
  localparam int unsigned Y_SPAN   = FB_H << SCALE_LOG2;
  // The framebuffer never extends past the visible raster
  localparam int unsigned X_LIM_I  = (X_SPAN < H_VISIBLE) ? X_SPAN : H_VISIBLE;
  localparam int unsigned Y_LIM_I  = (Y_SPAN < V_VISIBLE) ? Y_SPAN : V_VISIBLE;
  localparam int unsigned LIM_W    = COORD_W + 1;
  localparam logic [LIM_W-1:0] X_LIM = LIM_W'(X_LIM_I);
  localparam logic [LIM_W-1:0] Y_LIM = LIM_W'(Y_LIM_I);
  localparam int unsigned MUL_BITS = 16;
  localparam logic [MUL_BITS-1:0] FB_W_BITS = MUL_BITS'(FB_W);
  localparam int unsigned DLY      = 3;

  logic [COORD_W-1:0]   row;
  logic [COORD_W-1:0]   col;
  logic [FB_ADDR_W-1:0] addr_acc;
  logic                 in_range;
  logic [FB_ADDR_W-1:0] fb_addr_next;

  logic [DLY-1:0]       hsync_d;
  logic [DLY-1:0]       vsync_d;
  logic [DLY-1:0]       blank_d;

  logic                 vs_prev;
  logic                 vs_armed;
  rgb_t                 pal_rdata_c;

  // row*FB_W + col as a sum of shifted rows, one term per set bit of FB_W
  always_comb begin
    row      = y >> SCALE_LOG2;
    col      = x >> SCALE_LOG2;
    addr_acc = FB_ADDR_W'(col);
    for (int b = 0; b < int'(MUL_BITS); b++) begin
      if (FB_W_BITS[b]) begin
        addr_acc = addr_acc + (FB_ADDR_W'(row) << b);
      end
    end
    in_range     = ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
    fb_addr_next = in_range ? addr_acc : '0;
  end

  // Stage 1: registered framebuffer address
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_addr <= '0;
    end else begin
      fb_addr <= fb_addr_next;
    end
  end

  // Timing delay lines, matched to address + RAM + colour register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync_d <= '1;
      vsync_d <= '1;
      blank_d <= '0;
    end else begin
      hsync_d <= {hsync_d[DLY-2:0], hsync};
      vsync_d <= {vsync_d[DLY-2:0], vsync};
      blank_d <= {blank_d[DLY-2:0], blank_b};
    end
  end

  assign hsync_o   = hsync_d[DLY-1];
  assign vsync_o   = vsync_d[DLY-1];
  assign blank_b_o = blank_d[DLY-1];

  // Stage 3: colour lookup; blank_d[DLY-2] is the blank that lands with this rgb
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb <= '0;
    end else begin
      rgb <= blank_d[DLY-2] ? pal_rdata_c : '0;
    end
  end

  // Falling-vsync detector. vs_armed only sets once vsync has been seen
  // high, so a vsync held low across reset release is not a frame start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_prev     <= 1'b1;
      vs_armed    <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      vs_prev     <= vsync;
      vs_armed    <= vs_armed | vsync;
      frame_start <= vs_armed & vs_prev & ~vsync;
      if (frame_start) begin
        frame_count <= frame_count + FRAME_CNT_W'(1);
      end
    end
  end

  vga_palette u_palette (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (pal_we),
    .waddr   (pal_addr),
    .wdata   (pal_data),
    .commit  (frame_start),
    .raddr   (fb_data),
    .rdata_c (pal_rdata_c)
  );

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: drives the raster inputs directly,
// models a 1-cycle-latency framebuffer RAM, and scoreboards address, colour,
// timing and frame outputs against a reference palette/frame model.
module tb_vga_pixel_fetch;
  import vga_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [9:0]  x, y;
  logic        hsync, vsync, blank_b;
  logic [14:0] fb_addr;
  logic [3:0]  fb_data;
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [11:0] pal_data;
  logic        hsync_o, vsync_o, blank_b_o;
  logic [11:0] rgb;
  logic        frame_start;
  logic [7:0]  frame_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          due;
    logic [14:0] addr;
  } addr_exp_t;

  typedef struct {
    int          due;
    logic [3:0]  idx;
    logic        bl;
    logic        hs;
    logic        vs;
  } pix_exp_t;

  addr_exp_t aq[$];
  pix_exp_t  pq[$];

  logic [3:0]  mem [0:19199];
  logic [11:0] m_shadow [16];
  logic [11:0] m_act    [16];
  logic        m_vs_prev;
  logic        m_fs;
  logic [7:0]  m_fc;

  vga_pixel_fetch #(.FB_W(160), .FB_H(120), .SCALE_LOG2(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .x           (x),
    .y           (y),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank_b     (blank_b),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .pal_we      (pal_we),
    .pal_addr    (pal_addr),
    .pal_data    (pal_data),
    .hsync_o     (hsync_o),
    .vsync_o     (vsync_o),
    .blank_b_o   (blank_b_o),
    .rgb         (rgb),
    .frame_start (frame_start),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  // Synchronous framebuffer RAM, one cycle of read latency
  always @(posedge clk) begin
    if (fb_addr < 15'd19200) fb_data <= mem[fb_addr];
    else                     fb_data <= 4'h0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] exp_addr(input int px, input int py);
    if (px >= 640 || py >= 480) return 15'd0;
    return 15'((py / 4) * 160 + (px / 4));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_shadow[i] = 12'(i * 12'h111);
      m_act[i]    = 12'(i * 12'h111);
    end
    m_vs_prev = 1'b0;  // no high vsync observed since reset
    m_fs      = 1'b0;
    m_fc      = 8'd0;
  endtask

  // One clock edge: advance the reference model, then compare due entries
  task automatic tick();
    logic [11:0] act_pre [16];
    logic        fs_new;
    addr_exp_t   ae;
    pix_exp_t    pe;
    logic [11:0] er;
    @(posedge clk);
    act_pre = m_act;
    fs_new  = m_vs_prev && !vsync;
    if (m_fs) begin
      m_act = m_shadow;
      m_fc  = m_fc + 8'd1;
    end
    if (pal_we) m_shadow[pal_addr] = pal_data;
    m_vs_prev = vsync;
    m_fs      = fs_new;
    #1;
    cyc++;
    while (aq.size() > 0 && aq[0].due == cyc) begin
      ae = aq.pop_front();
      chk("fb_addr", 32'(fb_addr), 32'(ae.addr));
    end
    while (pq.size() > 0 && pq[0].due == cyc) begin
      pe = pq.pop_front();
      er = pe.bl ? act_pre[pe.idx] : 12'h000;
      chk("rgb", 32'(rgb), 32'(er));
      chk("hsync_o", 32'(hsync_o), 32'(pe.hs));
      chk("vsync_o", 32'(vsync_o), 32'(pe.vs));
      chk("blank_b_o", 32'(blank_b_o), 32'(pe.bl));
    end
    chk("frame_start", 32'(frame_start), 32'(m_fs));
    chk("frame_count", 32'(frame_count), 32'(m_fc));
  endtask

  task automatic step(input int sx, input int sy, input logic shs, input logic svs, input logic sbl);
    logic [14:0] a;
    x       = 10'(sx);
    y       = 10'(sy);
    hsync   = shs;
    vsync   = svs;
    blank_b = sbl;
    a = exp_addr(sx, sy);
    aq.push_back('{due: cyc + 1, addr: a});
    pq.push_back('{due: cyc + 3, idx: mem[a], bl: sbl, hs: shs, vs: svs});
    tick();
  endtask

  task automatic step_w(input int sx, input int sy, input logic shs, input logic svs,
                        input logic sbl, input logic [3:0] wa, input logic [11:0] wd);
    pal_we   = 1'b1;
    pal_addr = wa;
    pal_data = wd;
    step(sx, sy, shs, svs, sbl);
    pal_we   = 1'b0;
  endtask

  task automatic frame_pulse();
    step(0, 0, 1'b1, 1'b0, 1'b0);
    step(0, 0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_fb_addr"}, 32'(fb_addr), 32'd0);
    chk({tag, "_rgb"}, 32'(rgb), 32'h000);
    chk({tag, "_hsync_o"}, 32'(hsync_o), 32'd1);
    chk({tag, "_vsync_o"}, 32'(vsync_o), 32'd1);
    chk({tag, "_blank_b_o"}, 32'(blank_b_o), 32'd0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, "_frame_count"}, 32'(frame_count), 32'd0);
  endtask

  initial begin
    clk      = 1'b0;
    reset_n  = 1'b0;
    x        = '0;
    y        = '0;
    hsync    = 1'b1;
    vsync    = 1'b0;
    blank_b  = 1'b0;
    pal_we   = 1'b0;
    pal_addr = '0;
    pal_data = '0;
    for (int i = 0; i < 19200; i++) mem[i] = 4'($urandom_range(0, 15));
    mem[321] = 4'd5;
    mem[322] = 4'd3;
    mem[323] = 4'd7;
    model_reset();

    // Reset, released with vsync held low
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values("in_reset");
    reset_n = 1'b1;
    cyc     = 0;
    chk_reset_values("at_release");
    step(0, 0, 1'b1, 1'b0, 1'b0);
    chk("no_fs_low_vsync_0", 32'(frame_start), 32'd0);
    step(0, 0, 1'b1, 1'b0, 1'b0);
    chk("no_fs_low_vsync_1", 32'(frame_start), 32'd0);
    step(0, 0, 1'b1, 1'b1, 1'b0);

    // Addressing, alignment and blanking
    step(7, 9, 1'b1, 1'b1, 1'b1);
    step(639, 479, 1'b1, 1'b1, 1'b1);
    step(700, 10, 1'b1, 1'b1, 1'b1);
    step(10, 600, 1'b1, 1'b1, 1'b0);
    step(7, 9, 1'b0, 1'b1, 1'b0);
    step(8, 9, 1'b0, 1'b1, 1'b1);
    step(12, 9, 1'b1, 1'b1, 1'b1);
    step(7, 9, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(i * 83, i * 61, 1'(i % 2), 1'b1, 1'(i % 3 != 0));

    // Mid-frame palette write stays invisible until the next frame
    step_w(7, 9, 1'b1, 1'b1, 1'b1, 4'd5, 12'hF00);
    repeat (4) step(7, 9, 1'b1, 1'b1, 1'b1);
    frame_pulse();
    repeat (4) step(7, 9, 1'b1, 1'b1, 1'b1);

    // Write in the frame_start cycle reaches the shadow only
    step(0, 0, 1'b1, 1'b0, 1'b0);
    step_w(0, 0, 1'b1, 1'b1, 1'b0, 4'd3, 12'h0F0);
    repeat (4) step(8, 9, 1'b1, 1'b1, 1'b1);
    frame_pulse();
    repeat (4) step(8, 9, 1'b1, 1'b1, 1'b1);

    // Pending shadow write, then reset mid-line
    step_w(12, 9, 1'b1, 1'b1, 1'b1, 4'd7, 12'hABC);
    repeat (3) step(7, 9, 1'b1, 1'b1, 1'b1);
    #3 reset_n = 1'b0;
    #1;
    chk_reset_values("mid_line");
    aq.delete();
    pq.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(0, 0, 1'b1, 1'b1, 1'b0);
    step(0, 0, 1'b1, 1'b1, 1'b0);

    // 256 frames wrap the counter back to 0 (and commit the reset palette)
    for (int f = 0; f < 256; f++) frame_pulse();
    chk("frame_count_wrap", 32'(frame_count), 32'd0);
    repeat (4) step(12, 9, 1'b1, 1'b1, 1'b1);
    repeat (4) step(7, 9, 1'b1, 1'b1, 1'b1);
    repeat (3) step(0, 0, 1'b1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
